// File: rtl/fetch_pc_gen_if.sv
// Prediction-request channel between the fetch PC generator and br_pred_cnt.
//
// Handshake: there is no valid/ready pair and no backpressure on this channel.
// A request is a single-cycle active-low pulse on br_ with the looked-up PC on
// br_addr. The predictor always answers on pred_taken in the very next cycle.
// pred_taken carries meaning only in that cycle and is ignored at all other times.
//
// Signals
//   br_         master->slave  low: prediction request (BTB hit on a valid slot)
//   br_addr     master->slave  PC being predicted (equals fetch_pc)
//   pred_taken  slave->master  registered prediction for the previous request
interface fetch_pc_gen_if #(
  parameter int ADDR = 32
);
  logic            br_;
  logic [ADDR-1:0] br_addr;
  logic            pred_taken;

  modport master (output br_, output br_addr, input pred_taken);
  modport slave  (input br_, input br_addr, output pred_taken);
endinterface

// File: rtl/fetch_pc_gen.sv
// Front-end next-PC generator with a direct-mapped branch target buffer.
//
// The fetch PC is looked up in the BTB every cycle. A hit on a valid,
// non-stalled, non-redirected slot raises a prediction request. The answer
// comes back one cycle later; a taken answer squashes the fall-through slot
// and steers fetch to the BTB target. A backend redirect overrides everything.
//
// Ports
//   clk, reset_              clock, asynchronous active-low reset
//   stall_                   low: hold fetch (decode cannot accept)
//   redirect_, redirect_pc   low: backend flush to redirect_pc
//   bt_we_, bt_pc, bt_target low: install/overwrite a BTB entry
//   fetch_pc, fetch_v_       current fetch slot and its (active-low) valid
//   bp                       prediction-request channel (master side)
module fetch_pc_gen #(
  parameter int              ADDR     = 32,
  parameter int              BTB_D    = 64,
  parameter logic [ADDR-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             stall_,
  input  logic             redirect_,
  input  logic [ADDR-1:0]  redirect_pc,
  input  logic             bt_we_,
  input  logic [ADDR-1:0]  bt_pc,
  input  logic [ADDR-1:0]  bt_target,
  output logic [ADDR-1:0]  fetch_pc,
  output logic             fetch_v_,
  fetch_pc_gen_if.master   bp
);

  localparam int OFS = 2;
  localparam int IDX = $clog2(BTB_D);
  localparam int TAG = ADDR - IDX - OFS;

  // Architectural state
  logic [ADDR-1:0] pc_q, pc_d;
  logic            pend_v_q;
  logic [ADDR-1:0] pend_tgt_q;

  // BTB storage: only the valid bits need a reset
  logic [BTB_D-1:0] btb_valid_q;
  logic [TAG-1:0]   btb_tag_q [BTB_D];
  logic [ADDR-1:0]  btb_tgt_q [BTB_D];

  // Lookup on the current fetch PC
  logic [IDX-1:0] rd_idx;
  logic [TAG-1:0] rd_tag;
  logic           hit;

  // Write port from commit
  logic [IDX-1:0] wr_idx;
  logic [TAG-1:0] wr_tag;

  logic squash;
  logic slot_valid;
  logic req;

  // Instruction-offset bits never reach the PC; they are dropped on purpose.
  logic unused_low_bits;
  assign unused_low_bits = ^{redirect_pc[OFS-1:0], bt_pc[OFS-1:0], bt_target[OFS-1:0]};

  assign rd_idx = pc_q[IDX+OFS-1:OFS];
  assign rd_tag = pc_q[ADDR-1:IDX+OFS];
  assign wr_idx = bt_pc[IDX+OFS-1:OFS];
  assign wr_tag = bt_pc[ADDR-1:IDX+OFS];

  assign hit = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == rd_tag);

  // A taken answer to last cycle's request means the current slot holds the
  // fall-through instruction and must be thrown away.
  assign squash = pend_v_q & bp.pred_taken;

  // The slot is invalid while in reset, while the backend is flushing it,
  // or when it is the squashed fall-through of a taken branch.
  assign slot_valid = reset_ & redirect_ & ~squash;

  // One request per fetched branch: the slot must be valid and leaving this
  // cycle (not stalled), so a stalled hit requests only on release.
  assign req = hit & slot_valid & stall_;

  assign fetch_pc   = pc_q;
  assign fetch_v_   = ~slot_valid;
  assign bp.br_     = ~req;
  assign bp.br_addr = pc_q;

  // Next-PC selection in priority order
  always_comb begin
    pc_d = pc_q + ADDR'(1 << OFS);
    if (!redirect_) begin
      pc_d = {redirect_pc[ADDR-1:OFS], {OFS{1'b0}}};
    end else if (squash) begin
      pc_d = pend_tgt_q;
    end else if (!stall_) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      pc_q        <= {RESET_PC[ADDR-1:OFS], {OFS{1'b0}}};
      pend_v_q    <= 1'b0;
      pend_tgt_q  <= '0;
      btb_valid_q <= '0;
    end else begin
      pc_q <= pc_d;
      // Pending lives for exactly one cycle; a redirect already blocks req.
      pend_v_q <= req;
      if (req) begin
        pend_tgt_q <= btb_tgt_q[rd_idx];
      end
      // Commit writes proceed even during a redirect.
      if (!bt_we_) begin
        btb_valid_q[wr_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!bt_we_) begin
      btb_tag_q[wr_idx] <= wr_tag;
      btb_tgt_q[wr_idx] <= {bt_target[ADDR-1:OFS], {OFS{1'b0}}};
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;

  localparam int BTB_D = 64;

  // ---------------- clock / reset / stimulus signals ----------------
  logic        clk;
  logic        reset_;
  logic        stall_;
  logic        redirect_;
  logic [31:0] redirect_pc;
  logic        bt_we_;
  logic [31:0] bt_pc;
  logic [31:0] bt_target;
  logic [31:0] fetch_pc;
  logic        fetch_v_;

  fetch_pc_gen_if #(.ADDR(32)) bp_if ();

  fetch_pc_gen #(.ADDR(32), .BTB_D(BTB_D), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset_      (reset_),
    .stall_      (stall_),
    .redirect_   (redirect_),
    .redirect_pc (redirect_pc),
    .bt_we_      (bt_we_),
    .bt_pc       (bt_pc),
    .bt_target   (bt_target),
    .fetch_pc    (fetch_pc),
    .fetch_v_    (fetch_v_),
    .bp          (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // The BTB is held as two maps keyed by entry index: the full PC of the
  // branch that owns the entry, and its target. A lookup hits when the
  // owning PC equals the fetch PC above the offset bits.
  logic [31:0] m_btb_pc  [int];
  logic [31:0] m_btb_tgt [int];
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_pend_tgt;
  logic        m_squash, m_valid, m_hit, e_br, e_fv;
  int          m_ix;

  function automatic int btb_index(input logic [31:0] a);
    return int'((a >> 2) % BTB_D);
  endfunction

  always @(negedge clk) begin
    if (!reset_) begin
      m_pc       = 32'h0;
      m_pend     = 1'b0;
      m_pend_tgt = 32'h0;
      m_btb_pc.delete();
      m_btb_tgt.delete();
      chk("model_reset_pc", fetch_pc, 32'h0);
      chk("model_reset_v", {31'b0, fetch_v_}, 32'd1);
      chk("model_reset_br", {31'b0, bp_if.br_}, 32'd1);
    end else begin
      m_ix     = btb_index(m_pc);
      m_squash = m_pend && bp_if.pred_taken;
      m_valid  = redirect_ && !m_squash;
      m_hit    = m_btb_pc.exists(m_ix) && ((m_btb_pc[m_ix] >> 2) == (m_pc >> 2));
      e_br     = !(m_valid && m_hit && stall_);
      e_fv     = !m_valid;
      chk("model_fetch_pc", fetch_pc, m_pc);
      chk("model_fetch_v", {31'b0, fetch_v_}, {31'b0, e_fv});
      chk("model_br", {31'b0, bp_if.br_}, {31'b0, e_br});
      chk("model_br_addr", bp_if.br_addr, m_pc);
      // advance to the state after the coming posedge
      if (!redirect_)     m_pc = redirect_pc & ~32'h3;
      else if (m_squash)  m_pc = m_pend_tgt;
      else if (stall_)    m_pc = m_pc + 32'd4;
      m_pend = !e_br;
      if (!e_br) m_pend_tgt = m_btb_tgt[m_ix];
      if (!bt_we_) begin
        m_btb_pc[btb_index(bt_pc)]  = bt_pc;
        m_btb_tgt[btb_index(bt_pc)] = bt_target & ~32'h3;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Flush fetch to addr; returns in the first cycle fetching addr.
  task automatic go_to(input logic [31:0] addr);
    step();
    redirect_   = 1'b0;
    redirect_pc = addr;
    step();
    redirect_ = 1'b1;
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    reset_ = 1'b0; stall_ = 1'b1; redirect_ = 1'b1; redirect_pc = '0;
    bt_we_ = 1'b1; bt_pc = '0; bt_target = '0; bp_if.pred_taken = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_v", {31'b0, fetch_v_}, 32'd1);
    chk("reset_br", {31'b0, bp_if.br_}, 32'd1);
    chk("reset_pc", fetch_pc, 32'h0);
    step();
    reset_ = 1'b1;
    // sequential fetch, empty BTB; a stray pred_taken must be ignored
    bp_if.pred_taken = 1'b1;
    @(negedge clk);
    chk("seq_first_pc", fetch_pc, 32'h0);
    chk("seq_first_v", {31'b0, fetch_v_}, 32'd0);
    repeat (5) step();
    @(negedge clk);
    chk("seq_pc_14", fetch_pc, 32'h14);
    chk("seq_br_idle", {31'b0, bp_if.br_}, 32'd1);

    // train 0x10 -> 0x80
    step();
    bp_if.pred_taken = 1'b0;
    bt_we_ = 1'b0; bt_pc = 32'h10; bt_target = 32'h80;
    step();
    bt_we_ = 1'b1;
    redirect_ = 1'b0; redirect_pc = 32'h10;
    step();
    redirect_ = 1'b1;
    // taken prediction
    @(negedge clk);
    chk("taken_req_pc", fetch_pc, 32'h10);
    chk("taken_req_br", {31'b0, bp_if.br_}, 32'd0);
    step();
    bp_if.pred_taken = 1'b1;
    @(negedge clk);
    chk("taken_squash_pc", fetch_pc, 32'h14);
    chk("taken_squash_v", {31'b0, fetch_v_}, 32'd1);
    step();
    bp_if.pred_taken = 1'b0;
    @(negedge clk);
    chk("taken_tgt_pc", fetch_pc, 32'h80);
    chk("taken_tgt_v", {31'b0, fetch_v_}, 32'd0);

    // not-taken prediction: no bubble
    go_to(32'h10);
    @(negedge clk);
    chk("nt_req_br", {31'b0, bp_if.br_}, 32'd0);
    step();
    @(negedge clk);
    chk("nt_pc_14", fetch_pc, 32'h14);
    chk("nt_v_14", {31'b0, fetch_v_}, 32'd0);
    step();
    @(negedge clk);
    chk("nt_pc_18", fetch_pc, 32'h18);

    // stall on a hit: no request until release, then exactly one
    step();
    redirect_ = 1'b0; redirect_pc = 32'h10; stall_ = 1'b0;
    step();
    redirect_ = 1'b1;
    @(negedge clk);
    chk("stall_br", {31'b0, bp_if.br_}, 32'd1);
    step();
    @(negedge clk);
    chk("stall_hold_pc", fetch_pc, 32'h10);
    chk("stall_hold_br", {31'b0, bp_if.br_}, 32'd1);
    step();
    stall_ = 1'b1;
    @(negedge clk);
    chk("stall_rel_br", {31'b0, bp_if.br_}, 32'd0);
    step();
    bp_if.pred_taken = 1'b1;
    @(negedge clk);
    chk("stall_squash_br", {31'b0, bp_if.br_}, 32'd1);
    step();
    bp_if.pred_taken = 1'b0;
    @(negedge clk);
    chk("stall_tgt_pc", fetch_pc, 32'h80);

    // redirect in the cycle pred_taken=1 wins; misaligned target is aligned
    go_to(32'h10);
    step();
    bp_if.pred_taken = 1'b1;
    redirect_ = 1'b0; redirect_pc = 32'h202;
    @(negedge clk);
    chk("redir_slot_v", {31'b0, fetch_v_}, 32'd1);
    step();
    redirect_ = 1'b1;
    @(negedge clk);
    chk("redir_pc", fetch_pc, 32'h200);
    chk("redir_v", {31'b0, fetch_v_}, 32'd0);
    step();
    bp_if.pred_taken = 1'b0;
    @(negedge clk);
    chk("redir_next_pc", fetch_pc, 32'h204);

    // aliasing index, different tag
    go_to(32'h10 + (BTB_D << 2));
    @(negedge clk);
    chk("alias_br", {31'b0, bp_if.br_}, 32'd1);
    step();
    @(negedge clk);
    chk("alias_next_pc", fetch_pc, 32'h114);

    // simultaneous redirect and BTB write
    step();
    redirect_ = 1'b0; redirect_pc = 32'h40;
    bt_we_ = 1'b0; bt_pc = 32'h40; bt_target = 32'h100;
    step();
    redirect_ = 1'b1; bt_we_ = 1'b1;
    @(negedge clk);
    chk("sim_pc", fetch_pc, 32'h40);
    chk("sim_br", {31'b0, bp_if.br_}, 32'd0);
    step();
    bp_if.pred_taken = 1'b1;
    step();
    bp_if.pred_taken = 1'b0;
    @(negedge clk);
    chk("sim_tgt_pc", fetch_pc, 32'h100);

    // wrap modulo 2^32
    go_to(32'hFFFF_FFFC);
    step();
    @(negedge clk);
    chk("wrap_pc", fetch_pc, 32'h0);

    // reset mid-operation invalidates the BTB
    step();
    reset_ = 1'b0;
    @(negedge clk);
    chk("midrst_pc", fetch_pc, 32'h0);
    chk("midrst_v", {31'b0, fetch_v_}, 32'd1);
    step();
    reset_ = 1'b1;
    go_to(32'h10);
    @(negedge clk);
    chk("midrst_btb_br", {31'b0, bp_if.br_}, 32'd1);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
